// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake and the IF/ID pipeline register.
// Optional redirect counter port enabled by defining FETCH_REDIRECT_CNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        hazard,
  input  logic [15:0] branch,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_out,
  output logic        valid
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StFlush} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      pc_out_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    imem_req = 1'b0;
    unique case (state_q)
      StBoot: begin
        valid_d = 1'b0;
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = ~stall;
        if (imem_req && imem_ready && !hazard) begin
          instr_d  = imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 16'd2;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StFlush: begin
        state_d = StFetch;
        if (!stall) valid_d = 1'b0;
      end
      default: state_d = StBoot;
    endcase
    // Redirect wins over stall and drops any data returned this cycle.
    if (hazard && state_q != StBoot) begin
      pc_d    = branch;
      valid_d = 1'b0;
      state_d = StFlush;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign valid     = valid_q;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q <= 16'h0000;
    end else if (hazard) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: stall  input  1  downstream hold; IF/ID register and PC frozen while high.
REQ-005 Port: hazard  input  1  redirect request from branch resolution stage.
REQ-006 Port: branch  input  16  redirect target; sampled only when hazard=1.
REQ-007 Port: imem_req  output  1  instruction memory request.
REQ-008 Port: imem_addr  output  16  instruction memory address; always equals internal PC.
REQ-009 Port: imem_ready  input  1  memory response valid; imem_data valid in the same cycle.
REQ-010 Port: imem_data  input  16  instruction word from memory.
REQ-011 Port: instr  output  16  IF/ID instruction register.
REQ-012 Port: pc_out  output  16  IF/ID PC register: the address instr was fetched from.
REQ-013 Port: valid  output  1  IF/ID register holds a live instruction.
REQ-014 Port: redirect_cnt  output  16  redirect counter; present only under FETCH_REDIRECT_CNT_EN.

Function
REQ-015 FSM states: BOOT, FETCH, FLUSH; encoding is implementation choice.
REQ-016 BOOT: imem_req=0, valid=0; unconditional transition to FETCH next cycle.
REQ-017 FETCH: imem_req = ~stall; request held, address stable, until imem_ready=1 (multi-cycle latency allowed).
REQ-018 Accept = FETCH & imem_req & imem_ready & ~hazard; on accept: instr<=imem_data, pc_out<=PC, valid<=1, PC<=PC+2.
REQ-019 FETCH with no accept and stall=0: valid<=0 (bubble); with stall=1: instr, pc_out, valid, PC all hold.
REQ-020 hazard=1 in FETCH or FLUSH: PC<=branch, valid<=0, any same-cycle imem_data discarded, next state FLUSH; overrides stall.
REQ-021 FLUSH: imem_req=0, valid<=0 unless stall=1 (then hold); transition to FETCH next cycle unless hazard=1 again.
REQ-022 Priority per cycle: rst > hazard > stall > imem_ready.
REQ-023 PC arithmetic modulo 2^16: 16'hFFFE+2 wraps to 16'h0000; no overflow flag.
REQ-024 Odd branch target loaded unmodified; no alignment check.
REQ-025 Fetch-to-IF/ID latency: one cycle after imem_ready for zero-wait memory; sustained throughput one instruction/cycle.

Reset
REQ-026 On rst=1 (asynchronous): PC=RESET_PC, state=BOOT, instr=16'h0000, pc_out=16'h0000, valid=0, imem_req=0, redirect_cnt=0.
REQ-027 Reset mid-request abandons the outstanding fetch; a late imem_ready after reset release is ignored in BOOT.
REQ-028 First request issues the cycle after BOOT, with imem_addr=RESET_PC.

Configuration
REQ-029 Macro FETCH_REDIRECT_CNT_EN defined: redirect_cnt increments by 1 on every cycle with hazard=1 (rst inactive), wrapping 16'hFFFF->16'h0000.
REQ-030 Macro FETCH_REDIRECT_CNT_EN undefined: redirect_cnt port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset then zero-wait memory returning 16'hA000+addr -> imem_addr 0000,0002,0004; instr A000,A002,A004 with pc_out 0000,0002,0004 on consecutive cycles, valid=1.
REQ-032 imem_ready low 3 cycles at addr 0004 -> imem_addr held 0004, valid=0 for 3 cycles, then instr A004, pc_out 0004.
REQ-033 stall=1 for 2 cycles after instr A002 -> imem_req=0, instr/pc_out/valid hold A002/0002/1; fetch resumes at 0004.
REQ-034 hazard=1, branch=0040 coincident with imem_ready at 0006 -> data at 0006 dropped, valid=0 next cycle, one FLUSH cycle, next request at 0040; redirect_cnt=1 with macro.
REQ-035 RESET_PC=16'hFFFC, zero-wait memory -> addresses FFFC, FFFE, 0000, 0002; rst asserted mid-stream -> all outputs at reset values immediately.
